// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer: weight preload, then NUM_TILES feature-load/drain passes per job.
// Define SEQ_WATCHDOG_EN to add a per-phase load timeout with a sticky err output.
module systolic_tile_sequencer #(
    parameter int NUM_TILES    = 4,
    parameter int ROW_STRIDE   = 4,
    parameter int DRAIN_CYCLES = 3
`ifdef SEQ_WATCHDOG_EN
   ,parameter int TIMEOUT      = 63
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] feature_base_i,
    input  logic       is_WL_done_i,
    input  logic       is_FL_done_i,
    output logic       Weight_Preloader_en,
    output logic       Feature_Loader_en,
    output logic [5:0] feature_baseaddr,
    output logic       mode,
    output logic [2:0] c_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [2:0] LAST = 3'(NUM_TILES - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, SWITCH, LOAD_F, DRAIN, GAP, FINISH} state_t;

    state_t state_q, state_d;
    logic [2:0] tile_q, tile_d;
    logic [5:0] base_q, base_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [5:0] off_d;
    logic timeout;
    logic wpe_q, fle_q, mode_q, busy_q, done_q;
    logic [2:0] csel_q;
    logic [5:0] addr_q;

    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        base_d  = base_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: if (start) begin
                base_d  = feature_base_i;
                tile_d  = '0;
                state_d = LOAD_W;
            end
            LOAD_W: state_d = is_WL_done_i ? SWITCH : timeout ? IDLE : LOAD_W;
            SWITCH: state_d = LOAD_F;
            LOAD_F: if (is_FL_done_i) begin
                state_d = DRAIN;
                drain_d = DW'(DRAIN_CYCLES - 1);
            end else if (timeout) begin
                state_d = IDLE;
            end
            DRAIN: if (drain_q == '0) begin
                state_d = (tile_q == LAST) ? FINISH : GAP;
                tile_d  = (tile_q == LAST) ? tile_q : tile_q + 1'b1;
            end else begin
                drain_d = drain_q - 1'b1;
            end
            GAP:     state_d = LOAD_F;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Row pitch from tile[2:1], column step from tile[0]; wraps mod 64.
    assign off_d = 6'(tile_d[2:1]) * 6'(ROW_STRIDE) + 6'(tile_d[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tile_q  <= '0;
            base_q  <= '0;
            drain_q <= '0;
            wpe_q   <= 1'b0;
            fle_q   <= 1'b0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            csel_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            tile_q  <= tile_d;
            base_q  <= base_d;
            drain_q <= drain_d;
            wpe_q   <= state_d == LOAD_W;
            fle_q   <= state_d == LOAD_F;
            mode_q  <= state_d inside {SWITCH, LOAD_F, DRAIN, GAP};
            busy_q  <= state_d != IDLE;
            done_q  <= state_d == FINISH;
            csel_q  <= tile_d;
            addr_q  <= base_d + off_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_q;
    logic err_q, in_load, ph_done;
    assign in_load = state_q == LOAD_W || state_q == LOAD_F;
    assign ph_done = (state_q == LOAD_W) ? is_WL_done_i : is_FL_done_i;
    assign timeout = in_load && !ph_done && wd_q == WW'(TIMEOUT - 1);
    // Counter restarts whenever a load phase is (re)entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= (in_load && state_d == state_q) ? wd_q + 1'b1 : '0;
            err_q <= err_q | timeout;
        end
    end
    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign Weight_Preloader_en = wpe_q;
    assign Feature_Loader_en   = fle_q;
    assign mode                = mode_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign c_sel               = csel_q;
    assign feature_baseaddr    = addr_q;
endmodule
